// File: rtl/cnu_minsum_ppl.sv
// cnu_minsum_ppl -- pipelined min-sum check-node core.
//
// Takes one row of D sign-magnitude variable-to-check messages per en-high
// cycle. It returns the smallest and second-smallest active magnitudes, both
// offset-corrected, together with the index of the smallest, the XOR of the
// active signs and the per-input sign vector.
// Pipeline: stage 0 (mask + pairing), M = clog2(ceil(D/2)) merge stages and
// one output stage. Latency is M + 2 en-high cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset, clears every register
//   en         pipeline advance; low freezes every register
//   in_valid   qualifies in/deg when en is high
//   in         D messages, message i at [data_w*i +: data_w], MSB = sign
//   deg        run-time row degree, clamped to [2, D]
//   out_valid  result valid
//   min/min2   smallest / second-smallest active magnitude minus OFFSET (sat 0)
//   min_idx    index of the smallest active magnitude (lowest index on ties)
//   sign_prod  XOR of active signs
//   signs      per-input signs, masked positions read 0
module cnu_minsum_ppl #(
  parameter int data_w = 8,
  parameter int idx_w  = 8,
  parameter int D      = 5,
  parameter int OFFSET = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [data_w*D-1:0]  in,
  input  logic [idx_w-1:0]     deg,
  output logic                 out_valid,
  output logic [data_w-2:0]    min,
  output logic [data_w-2:0]    min2,
  output logic [idx_w-1:0]     min_idx,
  output logic                 sign_prod,
  output logic [D-1:0]         signs
);

  localparam int MAG_W = data_w - 1;
  localparam int P     = (D + 1) / 2;   // pairs formed at stage 0
  localparam int M     = $clog2(P);     // merge stages

  // Node count of pipeline level l (level 0 = registered pairs).
  function automatic int lvl_cnt(input int l);
    int n;
    n = P;
    for (int i = 0; i < l; i++) n = (n + 1) / 2;
    return n;
  endfunction

  // Position of level l's first node in the flattened node array.
  function automatic int lvl_off(input int l);
    int s;
    s = 0;
    for (int i = 0; i < l; i++) s += lvl_cnt(i);
    return s;
  endfunction

  localparam int TOT = lvl_off(M + 1);

  typedef struct packed {
    logic [MAG_W-1:0] m1;
    logic [MAG_W-1:0] m2;
    logic [idx_w-1:0] idx;
  } pair_t;

  // Side a always carries the lower indices, so a tie keeps a as the winner.
  function automatic pair_t merge(input pair_t a, input pair_t b);
    pair_t r;
    if (b.m1 < a.m1) begin
      r.m1  = b.m1;
      r.idx = b.idx;
      r.m2  = (a.m1 < b.m2) ? a.m1 : b.m2;
    end else begin
      r.m1  = a.m1;
      r.idx = a.idx;
      r.m2  = (b.m1 < a.m2) ? b.m1 : a.m2;
    end
    return r;
  endfunction

  function automatic logic [MAG_W-1:0] sub_off(input logic [MAG_W-1:0] m);
    return (m > MAG_W'(OFFSET)) ? m - MAG_W'(OFFSET) : '0;
  endfunction

  // ---------------- stage 0: degree clamp, masking, pairing ----------------
  logic [idx_w-1:0] deg_c;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    deg_c = deg;
    if (deg < idx_w'(2))      deg_c = idx_w'(2);
    else if (deg > idx_w'(D)) deg_c = idx_w'(D);
  end

  logic [MAG_W-1:0] mag [2*P];
  logic [D-1:0]     sgn0;

  for (genvar i = 0; i < D; i++) begin : g_mask
    logic act;
    assign act     = idx_w'(i) < deg_c;
    assign mag[i]  = act ? in[data_w*i +: MAG_W] : '1;
    assign sgn0[i] = act & in[data_w*i + MAG_W];
  end

  // Odd degree: the last input is paired with an all-ones filler at index D.
  if (D % 2 == 1) begin : g_filler
    assign mag[D] = '1;
  end

  pair_t pipe_d [TOT];
  pair_t pipe_q [TOT];

  for (genvar k = 0; k < P; k++) begin : g_pair
    localparam int A = 2 * k;
    localparam int B = 2 * k + 1;
    assign pipe_d[k] = (mag[B] < mag[A]) ? pair_t'{mag[B], mag[A], idx_w'(B)}
                                         : pair_t'{mag[A], mag[B], idx_w'(A)};
  end

  // ---------------- merge tree ----------------
  for (genvar l = 1; l <= M; l++) begin : g_lvl
    localparam int N_IN  = lvl_cnt(l - 1);
    localparam int O_IN  = lvl_off(l - 1);
    localparam int O_OUT = lvl_off(l);
    for (genvar j = 0; j < lvl_cnt(l); j++) begin : g_node
      if (2 * j + 1 < N_IN) begin : g_merge
        assign pipe_d[O_OUT+j] = merge(pipe_q[O_IN+2*j], pipe_q[O_IN+2*j+1]);
      end else begin : g_pass
        assign pipe_d[O_OUT+j] = pipe_q[O_IN+2*j];
      end
    end
  end

  // ---------------- registers ----------------
  logic         v_q  [M+1];
  logic         sp_q [M+1];
  logic [D-1:0] sg_q [M+1];

  // NOTE: the data pipeline is reset along with the valid bits, so an
  // asserted reset leaves no stale row anywhere, not just on the outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_q    <= '{default: '0};
      v_q       <= '{default: 1'b0};
      sp_q      <= '{default: 1'b0};
      sg_q      <= '{default: '0};
      out_valid <= 1'b0;
      min       <= '0;
      min2      <= '0;
      min_idx   <= '0;
      sign_prod <= 1'b0;
      signs     <= '0;
    end else if (en) begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value, which is what makes this a pipeline.
      pipe_q  <= pipe_d;
      v_q[0]  <= in_valid;
      sp_q[0] <= ^sgn0;
      sg_q[0] <= sgn0;
      for (int l = 1; l <= M; l++) begin
        v_q[l]  <= v_q[l-1];
        sp_q[l] <= sp_q[l-1];
        sg_q[l] <= sg_q[l-1];
      end
      out_valid <= v_q[M];
      min       <= sub_off(pipe_q[TOT-1].m1);
      min2      <= sub_off(pipe_q[TOT-1].m2);
      min_idx   <= pipe_q[TOT-1].idx;
      sign_prod <= sp_q[M];
      signs     <= sg_q[M];
    end
  end

endmodule

// File: tb/tb_cnu_minsum_ppl.sv
// Directed bench for cnu_minsum_ppl: a D=5 core, a D=5 core with OFFSET=2
// (sharing the same inputs) and a D=2 core.
module tb_cnu_minsum_ppl;

  logic        clk = 1'b0;
  logic        rst, en, in_valid;
  logic [39:0] in_v;
  logic [7:0]  deg;

  logic        ov, sp;
  logic [6:0]  mn, mn2;
  logic [7:0]  mi;
  logic [4:0]  sg;

  logic        o_ov, o_sp;
  logic [6:0]  o_mn, o_mn2;
  logic [7:0]  o_mi;
  logic [4:0]  o_sg;

  logic        iv2;
  logic [15:0] in2;
  logic [7:0]  deg2;
  logic        d2_ov, d2_sp;
  logic [6:0]  d2_mn, d2_mn2;
  logic [7:0]  d2_mi;
  logic [1:0]  d2_sg;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cnu_minsum_ppl #(.data_w(8), .idx_w(8), .D(5), .OFFSET(0)) u5 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in(in_v), .deg(deg),
    .out_valid(ov), .min(mn), .min2(mn2), .min_idx(mi), .sign_prod(sp), .signs(sg));

  cnu_minsum_ppl #(.data_w(8), .idx_w(8), .D(5), .OFFSET(2)) u5o (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in(in_v), .deg(deg),
    .out_valid(o_ov), .min(o_mn), .min2(o_mn2), .min_idx(o_mi), .sign_prod(o_sp), .signs(o_sg));

  cnu_minsum_ppl #(.data_w(8), .idx_w(8), .D(2), .OFFSET(0)) u2 (
    .clk(clk), .rst(rst), .en(en), .in_valid(iv2), .in(in2), .deg(deg2),
    .out_valid(d2_ov), .min(d2_mn), .min2(d2_mn2), .min_idx(d2_mi), .sign_prod(d2_sp), .signs(d2_sg));

  function automatic logic [39:0] pack5(input int m0, input int m1, input int m2,
                                        input int m3, input int m4, input logic [4:0] s);
    logic [39:0] r;
    r[7:0]   = {s[0], 7'(m0)};
    r[15:8]  = {s[1], 7'(m1)};
    r[23:16] = {s[2], 7'(m2)};
    r[31:24] = {s[3], 7'(m3)};
    r[39:32] = {s[4], 7'(m4)};
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; in_valid = 1'b0; in_v = '0; deg = 8'd5;
    iv2 = 1'b0; in2 = '0; deg2 = 8'd2;
    repeat (2) @(negedge clk);
    checks++;
    if ({ov, mn, mn2, mi, sp, sg} !== 29'd0) begin
      failures++; $display("FAIL reset_d5: got %h expected 0", {ov, mn, mn2, mi, sp, sg});
    end
    checks++;
    if ({o_ov, o_mn, o_mn2, o_mi, o_sp, o_sg} !== 29'd0) begin
      failures++; $display("FAIL reset_off: got %h expected 0", {o_ov, o_mn, o_mn2, o_mi, o_sp, o_sg});
    end
    checks++;
    if ({d2_ov, d2_mn, d2_mn2, d2_mi, d2_sp, d2_sg} !== 26'd0) begin
      failures++; $display("FAIL reset_d2: got %h expected 0", {d2_ov, d2_mn, d2_mn2, d2_mi, d2_sp, d2_sg});
    end
    rst = 1'b1;
  endtask

  task automatic test_duplicate_min();
    logic [27:0] got;
    int at, n;
    at = -1; n = 0; got = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ov) begin got = {mn, mn2, mi, sp, sg}; at = k; n++; end
      if (k == 0) begin
        in_v = pack5(10, 3, 7, 3, 20, 5'b00101); deg = 8'd5; in_valid = 1'b1;
      end else in_valid = 1'b0;
    end
    checks++;
    if (n !== 1) begin failures++; $display("FAIL dup_pulses: got %0d expected 1", n); end
    checks++;
    if (at !== 4) begin failures++; $display("FAIL dup_latency: got %0d expected 4", at); end
    checks++;
    if (got !== {7'd3, 7'd3, 8'd1, 1'b0, 5'b00101}) begin
      failures++; $display("FAIL dup_result: got %h expected %h", got, {7'd3, 7'd3, 8'd1, 1'b0, 5'b00101});
    end
  endtask

  task automatic test_degree_mask();
    logic [39:0] rin   [3];
    logic [7:0]  rdeg  [3];
    logic [27:0] exp_r [3];
    logic [27:0] got   [4];
    int at [4];
    int n;
    rin[0] = pack5(9, 4, 6, 1, 0, 5'b11111); rdeg[0] = 8'd3;
    rin[1] = pack5(9, 4, 6, 1, 0, 5'b11111); rdeg[1] = 8'd0;
    rin[2] = pack5(9, 4, 6, 1, 0, 5'b11111); rdeg[2] = 8'd200;
    exp_r[0] = {7'd4, 7'd6, 8'd1, 1'b1, 5'b00111};
    exp_r[1] = {7'd4, 7'd9, 8'd1, 1'b0, 5'b00011};
    exp_r[2] = {7'd0, 7'd1, 8'd4, 1'b1, 5'b11111};
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ov) begin
        if (n < 4) begin got[n] = {mn, mn2, mi, sp, sg}; at[n] = k; end
        n++;
      end
      if (k < 3) begin in_v = rin[k]; deg = rdeg[k]; in_valid = 1'b1; end
      else in_valid = 1'b0;
    end
    checks++;
    if (n !== 3) begin failures++; $display("FAIL mask_pulses: got %0d expected 3", n); end
    for (int r = 0; r < 3; r++) begin
      checks++;
      if (at[r] !== 4 + r || got[r] !== exp_r[r]) begin
        failures++;
        $display("FAIL mask_row%0d: got cycle %0d value %h expected cycle %0d value %h",
                 r, at[r], got[r], 4 + r, exp_r[r]);
      end
    end
  endtask

  task automatic test_offset();
    logic [27:0] got_o, got_m;
    int n;
    n = 0; got_o = '0; got_m = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o_ov) begin got_o = {o_mn, o_mn2, o_mi, o_sp, o_sg}; n++; end
      if (ov) got_m = {mn, mn2, mi, sp, sg};
      if (k == 0) begin
        in_v = pack5(1, 5, 8, 9, 12, 5'b00000); deg = 8'd5; in_valid = 1'b1;
      end else in_valid = 1'b0;
    end
    checks++;
    if (n !== 1 || got_o !== {7'd0, 7'd3, 8'd0, 1'b0, 5'b00000}) begin
      failures++;
      $display("FAIL offset_sat: got %0d pulses value %h expected 1 pulse value %h",
               n, got_o, {7'd0, 7'd3, 8'd0, 1'b0, 5'b00000});
    end
    checks++;
    if (got_m !== {7'd1, 7'd5, 8'd0, 1'b0, 5'b00000}) begin
      failures++; $display("FAIL offset_zero_ref: got %h expected %h", got_m, {7'd1, 7'd5, 8'd0, 1'b0, 5'b00000});
    end
  endtask

  task automatic test_stall();
    logic [39:0] rin   [3];
    logic [27:0] exp_r [3];
    logic [27:0] got   [4];
    logic [28:0] snap;
    int at [4];
    int n;
    rin[0] = pack5(50, 1, 60, 70, 80, 5'b10000);
    rin[1] = pack5(2, 40, 40, 40, 40, 5'b00000);
    rin[2] = pack5(40, 40, 40, 40, 3, 5'b11000);
    exp_r[0] = {7'd1, 7'd50, 8'd1, 1'b1, 5'b10000};
    exp_r[1] = {7'd2, 7'd40, 8'd0, 1'b0, 5'b00000};
    exp_r[2] = {7'd3, 7'd40, 8'd4, 1'b0, 5'b11000};
    n = 0; snap = '0;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (ov) begin
        if (n < 4) begin got[n] = {mn, mn2, mi, sp, sg}; at[n] = k; end
        n++;
      end
      if (k == 3) snap = {ov, mn, mn2, mi, sp, sg};
      if (k == 4 || k == 5) begin
        checks++;
        if ({ov, mn, mn2, mi, sp, sg} !== snap) begin
          failures++; $display("FAIL stall_hold_c%0d: got %h expected %h", k, {ov, mn, mn2, mi, sp, sg}, snap);
        end
      end
      if (k < 3) begin in_v = rin[k]; deg = 8'd5; in_valid = 1'b1; end
      else begin
        in_valid = 1'b0;
        in_v = pack5(0, 0, 0, 0, 0, 5'b11111);  // ignored while stalled
      end
      if (k == 3) en = 1'b0;
      if (k == 5) en = 1'b1;
    end
    checks++;
    if (n !== 3) begin failures++; $display("FAIL stall_pulses: got %0d expected 3", n); end
    for (int r = 0; r < 3; r++) begin
      checks++;
      if (at[r] !== 6 + r || got[r] !== exp_r[r]) begin
        failures++;
        $display("FAIL stall_row%0d: got cycle %0d value %h expected cycle %0d value %h",
                 r, at[r], got[r], 6 + r, exp_r[r]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [27:0] got;
    int at, n;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 3) begin in_v = pack5(k + 10, 60, 60, 60, 60, 5'b00001); deg = 8'd5; in_valid = 1'b1; end
      else in_valid = 1'b0;
    end
    // First row of the burst is on the outputs now.
    checks++;
    if (ov !== 1'b1) begin failures++; $display("FAIL rst_pre_valid: got %b expected 1", ov); end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({ov, mn, mn2, mi, sp, sg} !== 29'd0) begin
      failures++; $display("FAIL rst_async_clear: got %h expected 0", {ov, mn, mn2, mi, sp, sg});
    end
    #2 rst = 1'b1;
    in_v = pack5(30, 20, 25, 26, 27, 5'b00000); deg = 8'd5; in_valid = 1'b1;
    at = -1; n = 0; got = '0;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (ov) begin got = {mn, mn2, mi, sp, sg}; at = k; n++; end
    end
    checks++;
    if (n !== 1 || at !== 4) begin
      failures++; $display("FAIL rst_after_release: got %0d pulses at cycle %0d expected 1 at cycle 4", n, at);
    end
    checks++;
    if (got !== {7'd20, 7'd25, 8'd1, 1'b0, 5'b00000}) begin
      failures++; $display("FAIL rst_first_row: got %h expected %h", got, {7'd20, 7'd25, 8'd1, 1'b0, 5'b00000});
    end
  endtask

  task automatic test_min_degree();
    logic [24:0] got [3];
    int at [3];
    int n;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (d2_ov) begin
        if (n < 3) begin got[n] = {d2_mn, d2_mn2, d2_mi, d2_sp, d2_sg}; at[n] = k; end
        n++;
      end
      if (k == 0) begin in2 = {1'b0, 7'd127, 1'b1, 7'd127}; deg2 = 8'd2; iv2 = 1'b1; end
      else if (k == 1) begin in2 = {1'b0, 7'd5, 1'b0, 7'd5}; deg2 = 8'd9; iv2 = 1'b1; end
      else iv2 = 1'b0;
    end
    checks++;
    if (n !== 2) begin failures++; $display("FAIL d2_pulses: got %0d expected 2", n); end
    checks++;
    if (at[0] !== 2 || got[0] !== {7'd127, 7'd127, 8'd0, 1'b1, 2'b01}) begin
      failures++;
      $display("FAIL d2_allmax: got cycle %0d value %h expected cycle 2 value %h",
               at[0], got[0], {7'd127, 7'd127, 8'd0, 1'b1, 2'b01});
    end
    checks++;
    if (at[1] !== 3 || got[1] !== {7'd5, 7'd5, 8'd0, 1'b0, 2'b00}) begin
      failures++;
      $display("FAIL d2_deg_clamp: got cycle %0d value %h expected cycle 3 value %h",
               at[1], got[1], {7'd5, 7'd5, 8'd0, 1'b0, 2'b00});
    end
  endtask

  initial begin
    test_reset();
    test_duplicate_min();
    test_degree_mask();
    test_offset();
    test_stall();
    test_reset_midstream();
    test_min_degree();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
